// File: rtl/keypad_scan_if.sv
// Keypad pin and key-code bundle between the scanner and the board/game side.
// The scanner uses the slave view; the pins/keypad side uses the master view.
interface keypad_scan_if;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic [4:0] key;
  logic [4:0] key_pulse;

  modport master (
    output key_row,
    input  key_col,
    input  key,
    input  key_pulse
  );

  modport slave (
    input  key_row,
    output key_col,
    output key,
    output key_pulse
  );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner: one-cold column drive, 2-flop row synchroniser,
// frame-level debounce and {valid, code} encoding for the key / key_pulse bus.
module keypad_scan #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic         clk,
  input  logic         rst,
  keypad_scan_if.slave kp
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int RUN_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(DEBOUNCE_FRAMES);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
  localparam logic [4:0]       NONE     = 5'h00;

  // Frame bit index is col*4 + row; returns the printed legend of that key.
  function automatic logic [3:0] code_of(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h4;
      4'd2:    code = 4'h7;
      4'd3:    code = 4'hE;
      4'd4:    code = 4'h2;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h8;
      4'd7:    code = 4'h0;
      4'd8:    code = 4'h3;
      4'd9:    code = 4'h6;
      4'd10:   code = 4'h9;
      4'd11:   code = 4'hF;
      4'd12:   code = 4'hA;
      4'd13:   code = 4'hB;
      4'd14:   code = 4'hC;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  logic [3:0]       sync1_q, sync2_q;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [15:0]      frame_q;
  logic             eval_q, eval_d;
  logic [4:0]       prev_q, stable_q, key_pulse_q;
  logic [RUN_W-1:0] run_q, run_d;
  logic             sample;
  logic [4:0]       cand;
  logic             accept;

  assign sample = (div_cnt_q == DIV_LAST);

  always_comb begin
    div_cnt_d = sample ? '0 : div_cnt_q + 1'b1;
    col_idx_d = sample ? col_idx_q + 2'd1 : col_idx_q;
    eval_d    = sample && (col_idx_q == 2'd3);
  end

  // Walk downward so the lowest pressed scan index is the one that sticks.
  always_comb begin
    cand = NONE;
    for (int i = 15; i >= 0; i--) begin
      if (frame_q[i]) cand = {1'b1, code_of(4'(i))};
    end
  end

  always_comb begin
    if (cand == prev_q) run_d = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
    else                run_d = RUN_ONE;
    accept = eval_q && (run_d == RUN_MAX) && (cand != stable_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 4'b1111;
      sync2_q     <= 4'b1111;
      div_cnt_q   <= '0;
      col_idx_q   <= 2'd0;
      frame_q     <= '0;
      eval_q      <= 1'b0;
      prev_q      <= NONE;
      stable_q    <= NONE;
      run_q       <= '0;
      key_pulse_q <= NONE;
    end else begin
      sync1_q     <= kp.key_row;
      sync2_q     <= sync1_q;
      div_cnt_q   <= div_cnt_d;
      col_idx_q   <= col_idx_d;
      eval_q      <= eval_d;
      key_pulse_q <= NONE;
      if (sample) frame_q[{col_idx_q, 2'b00} +: 4] <= ~sync2_q;
      // Evaluation never coincides with a sample because SCAN_DIV >= 4.
      if (eval_q) begin
        frame_q <= '0;
        prev_q  <= cand;
        run_q   <= run_d;
        if (accept) begin
          stable_q    <= cand;
          // NONE encodes as zero, so an accepted release yields no pulse.
          key_pulse_q <= cand;
        end
      end
    end
  end

  assign kp.key_col   = ~(4'b0001 << col_idx_q);
  assign kp.key       = stable_q;
  assign kp.key_pulse = key_pulse_q;

endmodule
